// File: rtl/rr_report_pkg.sv
// Shared types for the RR report transmitter: FSM states, buffered entry layout, frame length.
// The frame grows by a checksum byte when RR_REPORT_CHECKSUM_EN is defined.
package rr_report_pkg;

    typedef enum logic {IDLE, SEND} tx_state_t;

    localparam int PAYLOAD_BYTES = 6;
    localparam int WORD_BITS     = 24;

`ifdef RR_REPORT_CHECKSUM_EN
    localparam int FRAME_LEN = PAYLOAD_BYTES + 2;
`else
    localparam int FRAME_LEN = PAYLOAD_BYTES + 1;
`endif

    // Words are stored pre-extended to 24 bits so the frame bytes slice out directly.
    typedef struct packed {
        logic [WORD_BITS-1:0] location;
        logic [WORD_BITS-1:0] period;
    } rr_entry_t;

endpackage

// File: rtl/rr_report_fifo.sv
// Synchronous show-ahead FIFO of rr_entry_t; head is valid whenever empty is low.
// Latency: a push is visible at head one cycle later; push while full is the caller's job to prevent.
module rr_report_fifo
    import rr_report_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  rr_entry_t wr_data,
    output rr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    rr_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/rr_report_tx.sv
// Buffers RR period/R-peak results and serializes each into a SYNC-led byte frame (checksum byte with RR_REPORT_CHECKSUM_EN).
// Latency: update pulse at N -> SYNC byte valid at N+2; frames run back-to-back with no bubble.
// Backpressure: byte and valid hold while !i_tx_ready; results arriving with the FIFO full are dropped and counted.
module rr_report_tx
    import rr_report_pkg::*;
#(
    parameter int         CTR_WIDTH  = 22,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ce,
    input  logic [CTR_WIDTH-1:0] i_rr_period,
    input  logic                 i_rr_period_updated,
    input  logic [CTR_WIDTH-1:0] i_rpeak_location,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_busy,
    output logic                 o_overflow,
    output logic [7:0]           o_drop_cnt
);

    if (CTR_WIDTH > WORD_BITS || CTR_WIDTH < 1) begin : g_bad_ctr_width
        $error("rr_report_tx: CTR_WIDTH must be in 1..24");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rr_report_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t state;
    tx_state_t state_nxt;
    rr_entry_t head;
    rr_entry_t wr_entry;
    rr_entry_t frame;
    logic [2:0] idx;
    logic       full;
    logic       empty;
    logic       capture;
    logic       push;
    logic       pop;
    logic       hs;
    logic       last_byte;
    logic       drop;

    assign wr_entry.location = WORD_BITS'(i_rpeak_location);
    assign wr_entry.period   = WORD_BITS'(i_rr_period);

    assign capture   = i_ce && i_rr_period_updated;
    assign hs        = (state == SEND) && i_tx_ready;
    assign last_byte = (idx == 3'(FRAME_LEN - 1));
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign pop       = !empty && ((state == IDLE) || (hs && last_byte));
    assign push      = capture && (!full || pop);
    assign drop      = capture && full && !pop;

    rr_report_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = SEND;
            SEND:    if (hs && last_byte && empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx   <= '0;
            frame <= '0;
        end else if (pop) begin
            idx   <= '0;
            frame <= head;
        end else if (hs) begin
            idx   <= idx + 1'b1;
        end
    end

`ifdef RR_REPORT_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = frame.period[23:16]   ^ frame.period[15:8]   ^ frame.period[7:0]
                    ^ frame.location[23:16] ^ frame.location[15:8] ^ frame.location[7:0];
`endif

    always_comb begin
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        if (state == SEND) begin
            o_tx_valid = 1'b1;
            case (idx)
                3'd0:    o_tx_data = SYNC_BYTE;
                3'd1:    o_tx_data = frame.period[23:16];
                3'd2:    o_tx_data = frame.period[15:8];
                3'd3:    o_tx_data = frame.period[7:0];
                3'd4:    o_tx_data = frame.location[23:16];
                3'd5:    o_tx_data = frame.location[15:8];
                3'd6:    o_tx_data = frame.location[7:0];
`ifdef RR_REPORT_CHECKSUM_EN
                3'd7:    o_tx_data = checksum;
`endif
                default: o_tx_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (o_drop_cnt != 8'hFF) begin
                o_drop_cnt <= o_drop_cnt + 1'b1;
            end
        end
    end

    assign o_busy = (state == SEND) || !empty;

endmodule

// File: tb/tb_rr_report_tx.sv
// Randomized and directed bench for rr_report_tx against a queue-based frame model.
// Frame length follows RR_REPORT_CHECKSUM_EN exactly like the design.
module tb_rr_report_tx;

    localparam int DEPTH = 4;
`ifdef RR_REPORT_CHECKSUM_EN
    localparam int FL = 8;
`else
    localparam int FL = 7;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        upd = 1'b0;
    logic        ready = 1'b0;
    logic [21:0] per = '0;
    logic [21:0] loc = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    rr_report_tx dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_ce                (ce),
        .i_rr_period         (per),
        .i_rr_period_updated (upd),
        .i_rpeak_location    (loc),
        .o_tx_data           (tx_data),
        .o_tx_valid          (tx_valid),
        .i_tx_ready          (ready),
        .o_busy              (busy),
        .o_overflow          (overflow),
        .o_drop_cnt          (drop_cnt)
    );

    typedef struct packed {
        logic [23:0] per;
        logic [23:0] loc;
    } res_t;

    int          vectors = 0;
    int          errors = 0;
    bit          cmp_en = 0;
    res_t        mq[$];
    bit          m_send = 0;
    int          m_pos = 0;
    logic [7:0]  m_frame [8];
    bit          m_ovf = 0;
    int          m_drop = 0;
    logic [7:0]  rx[$];
    logic [7:0]  single_exp [8] = '{8'hA5, 8'h00, 8'h03, 8'h20, 8'h01, 8'h23, 8'h45, 8'h44};
    logic [21:0] b2b_per [3];
    logic [21:0] b2b_loc [3];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void load_frame(res_t r);
        m_frame[0] = 8'hA5;
        m_frame[1] = r.per[23:16];
        m_frame[2] = r.per[15:8];
        m_frame[3] = r.per[7:0];
        m_frame[4] = r.loc[23:16];
        m_frame[5] = r.loc[15:8];
        m_frame[6] = r.loc[7:0];
        m_frame[7] = m_frame[1] ^ m_frame[2] ^ m_frame[3] ^ m_frame[4] ^ m_frame[5] ^ m_frame[6];
    endfunction

    // Reference: a queue of pending results plus the frame currently on the wire.
    always @(posedge clk) begin
        res_t nr;
        bit   do_pop;
        if (!rst && tx_valid && ready) rx.push_back(tx_data);
        if (rst) begin
            mq.delete();
            m_send = 0;
            m_pos  = 0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            do_pop = 0;
            if (!m_send) begin
                do_pop = (mq.size() > 0);
            end else if (ready) begin
                if (m_pos == FL - 1) begin
                    if (mq.size() > 0) do_pop = 1;
                    else m_send = 0;
                end else begin
                    m_pos++;
                end
            end
            if (do_pop) begin
                load_frame(mq.pop_front());
                m_send = 1;
                m_pos  = 0;
            end
            if (ce && upd) begin
                if (mq.size() < DEPTH) begin
                    nr.per = {2'b00, per};
                    nr.loc = {2'b00, loc};
                    mq.push_back(nr);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", tx_valid, m_send);
            chk("data", tx_data, m_send ? m_frame[m_pos] : 8'h00);
            chk("busy", busy, m_send || (mq.size() > 0));
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(logic [21:0] p, logic [21:0] l);
        per = p;
        loc = l;
        upd = 1'b1;
        step();
        upd = 1'b0;
    endtask

    task automatic check_single(string nm);
        chk({nm, "_len"}, rx.size(), FL);
        for (int i = 0; i < FL && i < rx.size(); i++) begin
            chk(nm, rx[i], single_exp[i]);
        end
    endtask

    initial begin
        step();
        step();
        cmp_en = 1;
        rst = 1'b0;
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);

        // Single frame with first-byte latency
        ce = 1'b1;
        ready = 1'b1;
        rx.delete();
        pulse(22'h000320, 22'h012345);
        chk("lat_n1_valid", tx_valid, 0);
        chk("lat_n1_busy", busy, 1);
        step();
        chk("lat_n2_valid", tx_valid, 1);
        chk("lat_n2_data", tx_data, 8'hA5);
        repeat (10) step();
        check_single("single");

        // Same frame under alternating backpressure
        rx.delete();
        pulse(22'h000320, 22'h012345);
        for (int i = 0; i < 30; i++) begin
            ready = i[0];
            step();
        end
        check_single("bp");

        // Three results two cycles apart
        ready = 1'b1;
        rx.delete();
        for (int k = 0; k < 3; k++) begin
            b2b_per[k] = 22'($urandom);
            b2b_loc[k] = 22'($urandom);
            pulse(b2b_per[k], b2b_loc[k]);
            step();
        end
        repeat (30) step();
        chk("b2b_len", rx.size(), 3 * FL);
        for (int k = 0; k < 3 && rx.size() >= 3 * FL; k++) begin
            chk("b2b_sync", rx[k*FL], 8'hA5);
            chk("b2b_per_lo", rx[k*FL+3], b2b_per[k][7:0]);
            chk("b2b_loc_lo", rx[k*FL+6], b2b_loc[k][7:0]);
        end
        chk("b2b_busy_end", busy, 0);

        // Overflow: one result in the frame register, four in the FIFO, two dropped
        ready = 1'b0;
        rx.delete();
        for (int k = 0; k < 7; k++) pulse(22'(k + 1), 22'(100 + k));
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_cnt, 2);
        ready = 1'b1;
        repeat (60) step();
        chk("ovf_len", rx.size(), 5 * FL);
        for (int f = 0; f < 5 && rx.size() >= 5 * FL; f++) begin
            chk("ovf_order_per", rx[f*FL+3], f + 1);
            chk("ovf_order_loc", rx[f*FL+6], 100 + f);
        end

        // Drop counter saturation
        ready = 1'b0;
        for (int k = 0; k < 300; k++) pulse(22'h001000 + 22'(k), 22'(k));
        chk("sat_drop", drop_cnt, 255);

        // Reset while byte 3 is on the bus
        ready = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_ovf", overflow, 0);
        rx.delete();
        pulse(22'h000320, 22'h012345);
        repeat (12) step();
        check_single("post_rst");

        // Capture disabled
        ce = 1'b0;
        rx.delete();
        pulse(22'h000001, 22'h000002);
        repeat (10) step();
        chk("ce0_len", rx.size(), 0);
        chk("ce0_busy", busy, 0);
        chk("ce0_drop", drop_cnt, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            ce    = ($urandom_range(0, 7) != 0);
            upd   = ($urandom_range(0, 3) == 0);
            per   = 22'($urandom);
            loc   = 22'($urandom);
            rst   = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;
        upd = 1'b0;
        ready = 1'b1;
        repeat (100) step();
        chk("drain_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
